// File: rtl/control_logic_if.sv
// Handshake bundle between the ID/OF/EX/WB pipeline and the hazard controller.
// The master drives stage status and ID masks; the slave returns hold requests and scoreboard state.
interface control_logic_if #(
  parameter int NREGS = 16,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [NREGS-1:0] id_request;
  logic [NREGS-1:0] id_provide;
  logic             of_busy;
  logic             ex_busy;
  logic             wb_busy;
  logic             nop_id;
  logic             nop_of;
  logic             nop_ex;
  logic             nop_wb;
  logic [NREGS-1:0] busy_regs;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_request, id_provide, of_busy, ex_busy, wb_busy,
    input  nop_id, nop_of, nop_ex, nop_wb, busy_regs, stall_count
  );

  modport slave (
    input  id_valid, id_request, id_provide, of_busy, ex_busy, wb_busy,
    output nop_id, nop_of, nop_ex, nop_wb, busy_regs, stall_count
  );
endinterface

// File: rtl/control_logic.sv
// Register-scoreboard hazard controller: shadows the write masks in OF/EX/WB,
// stalls ID on read-after-write conflicts (no forwarding) and counts ID stall cycles.
module control_logic #(
  parameter int NREGS = 16,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  control_logic_if.slave  bus
);

  logic [NREGS-1:0] of_mask_reg, of_mask_next;
  logic [NREGS-1:0] ex_mask_reg, ex_mask_next;
  logic [NREGS-1:0] wb_mask_reg, wb_mask_next;
  logic [CNT_W-1:0] stall_count_reg, stall_count_next;
  logic [NREGS-1:0] busy_bits;
  logic [NREGS-1:0] hit_bits;
  logic             nop_id;
  logic             of_adv, ex_adv, wb_adv;

  // Per-register scoreboard: a register is busy while any stage still carries its write.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign busy_bits[gi] = of_mask_reg[gi] | ex_mask_reg[gi] | wb_mask_reg[gi];
      assign hit_bits[gi]  = bus.id_request[gi] & busy_bits[gi];
    end
  endgenerate

  assign nop_id = bus.id_valid & (|hit_bits);

  // A stage moves only when it and everything downstream of it can complete.
  assign wb_adv = ~bus.wb_busy;
  assign ex_adv = ~bus.ex_busy & wb_adv;
  assign of_adv = ~bus.of_busy & ex_adv;

  always_comb begin
    of_mask_next     = of_mask_reg;
    ex_mask_next     = ex_mask_reg;
    wb_mask_next     = wb_mask_reg;
    stall_count_next = stall_count_reg;

    if (of_adv) begin
      of_mask_next = (bus.id_valid && !nop_id) ? bus.id_provide : '0;
    end
    if (ex_adv) begin
      ex_mask_next = bus.of_busy ? '0 : of_mask_reg;
    end
    if (wb_adv) begin
      wb_mask_next = bus.ex_busy ? '0 : ex_mask_reg;
    end
    // Saturate rather than wrap so long-running statistics never read low.
    if (nop_id && (stall_count_reg != '1)) begin
      stall_count_next = stall_count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      of_mask_reg     <= '0;
      ex_mask_reg     <= '0;
      wb_mask_reg     <= '0;
      stall_count_reg <= '0;
    end else begin
      of_mask_reg     <= of_mask_next;
      ex_mask_reg     <= ex_mask_next;
      wb_mask_reg     <= wb_mask_next;
      stall_count_reg <= stall_count_next;
    end
  end

  assign bus.nop_id      = nop_id;
  assign bus.nop_of      = bus.of_busy;
  assign bus.nop_ex      = bus.ex_busy;
  assign bus.nop_wb      = bus.wb_busy;
  assign bus.busy_regs   = busy_bits;
  assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_control_logic.sv
// Randomized scoreboard bench for control_logic: an in-flight instruction list models
// the pipeline, expected outputs are queued per cycle and a monitor compares them.
module tb_control_logic;

  logic clk;
  logic reset;

  control_logic_if #(.NREGS(16), .CNT_W(32)) bus_a ();
  control_logic_if #(.NREGS(16), .CNT_W(4))  bus_b ();

  control_logic #(.NREGS(16), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  // Narrow-counter copy fed with identical stimulus to reach saturation quickly.
  control_logic #(.NREGS(16), .CNT_W(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  assign bus_b.id_valid   = bus_a.id_valid;
  assign bus_b.id_request = bus_a.id_request;
  assign bus_b.id_provide = bus_a.id_provide;
  assign bus_b.of_busy    = bus_a.of_busy;
  assign bus_b.ex_busy    = bus_a.ex_busy;
  assign bus_b.wb_busy    = bus_a.wb_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mask;
    int          stage;   // 1 = OF, 2 = EX, 3 = WB
  } inst_t;

  typedef struct {
    logic [15:0] busy;
    logic        nop_id;
    logic        nop_of;
    logic        nop_ex;
    logic        nop_wb;
    longint      st32;
    longint      st4;
  } exp_t;

  inst_t  pipe[$];
  exp_t   sb[$];
  longint st32;
  longint st4;
  int     total;
  int     bad;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] m = '0;
    foreach (pipe[i]) m |= pipe[i].mask;
    return m;
  endfunction

  task automatic model_step(input bit rst_n, input bit v, input logic [15:0] req,
                            input logic [15:0] prov, input bit ob, input bit eb, input bit wbb);
    inst_t nq[$];
    bit    haz;
    int    s;
    if (!rst_n) begin
      pipe.delete();
      st32 = 0;
      st4  = 0;
      return;
    end
    haz = v && ((req & model_busy()) != 16'h0);
    if (haz) begin
      if (st32 < 64'hFFFF_FFFF) st32++;
      if (st4 < 15) st4++;
    end
    // Deepest busy stage is the stall point: it and everything upstream hold,
    // the slot after it receives a bubble, everything downstream moves on.
    s = wbb ? 3 : (eb ? 2 : (ob ? 1 : 0));
    foreach (pipe[i]) begin
      inst_t e = pipe[i];
      if (e.stage > s) e.stage++;
      if (e.stage <= 3) nq.push_back(e);
    end
    if (s == 0 && v && !haz && prov != 16'h0) nq.push_back('{mask: prov, stage: 1});
    pipe = nq;
  endtask

  task automatic cycle(input bit rst_n, input bit v, input logic [15:0] req,
                       input logic [15:0] prov, input bit ob, input bit eb, input bit wbb);
    exp_t e;
    @(negedge clk);
    reset            = rst_n;
    bus_a.id_valid   = v;
    bus_a.id_request = req;
    bus_a.id_provide = prov;
    bus_a.of_busy    = ob;
    bus_a.ex_busy    = eb;
    bus_a.wb_busy    = wbb;
    e.busy   = model_busy();
    e.nop_id = v && ((req & e.busy) != 16'h0);
    e.nop_of = ob;
    e.nop_ex = eb;
    e.nop_wb = wbb;
    e.st32   = st32;
    e.st4    = st4;
    sb.push_back(e);
    model_step(rst_n, v, req, prov, ob, eb, wbb);
  endtask

  function automatic logic [15:0] rand_mask();
    logic [15:0] m = 16'h1 << $urandom_range(0, 3);
    if ($urandom_range(0, 2) == 0) m |= 16'h1 << $urandom_range(0, 15);
    return m;
  endfunction

  // Monitor: compares one queued expectation per cycle, sampled mid low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("busy_regs", longint'(bus_a.busy_regs), longint'(e.busy));
        check("nop_id",    longint'(bus_a.nop_id),    longint'(e.nop_id));
        check("nop_of",    longint'(bus_a.nop_of),    longint'(e.nop_of));
        check("nop_ex",    longint'(bus_a.nop_ex),    longint'(e.nop_ex));
        check("nop_wb",    longint'(bus_a.nop_wb),    longint'(e.nop_wb));
        check("stall_count",     longint'(bus_a.stall_count), e.st32);
        check("stall_count_sat", longint'(bus_b.stall_count), e.st4);
        check("sat_busy_regs",   longint'(bus_b.busy_regs),   longint'(e.busy));
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    st32  = 0;
    st4   = 0;
    reset = 1'b0;
    bus_a.id_valid   = 1'b0;
    bus_a.id_request = '0;
    bus_a.id_provide = '0;
    bus_a.of_busy    = 1'b0;
    bus_a.ex_busy    = 1'b0;
    bus_a.wb_busy    = 1'b0;

    // Reset with random inputs; busy outputs must still follow their inputs.
    repeat (2) cycle(1'b0, 1'($urandom), rand_mask(), rand_mask(),
                     1'($urandom), 1'($urandom), 1'($urandom));

    // RAW chain through RAX: exactly three stall cycles.
    cycle(1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    #2;
    check("raw_chain_stalls", longint'(bus_a.stall_count), 3);

    // Independent instructions, then self-reference.
    cycle(1'b1, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0008, 16'h0008, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // EX busy holding a write to register 4 while ID waits on it.
    cycle(1'b1, 1'b1, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Saturation on the narrow counter: a hazard pinned by a busy OF stage.
    repeat (2) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
    #2;
    check("sat_hold", longint'(bus_b.stall_count), 15);

    // Randomized traffic with occasional busy stages and resets.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
            rand_mask(), rand_mask(),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 8) == 0));
    end

    repeat (3) @(negedge clk);
    #4;
    check("scoreboard_drained", longint'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
